fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter width in bits.
REQ-002 SHALL have parameter BOOT_ADDR, default 0, instruction-memory address holding the reset vector.
REQ-003 SHALL have parameter INT_OPCODE, default the shared OP_INT value, 5-bit opcode injected on interrupt.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port imem_addr, output, PC_W, instruction-memory read address, combinationally equal to pc.
REQ-007 SHALL have port imem_data, input, 16, instruction word at imem_addr, available in the same cycle.
REQ-008 SHALL have port stall, input, 1, hold pc and the IF/ID register.
REQ-009 SHALL have port flush, input, 1, replace the next IF/ID contents with a bubble.
REQ-010 SHALL have port branch_taken, input, 1, redirect fetch to branch_target.
REQ-011 SHALL have port branch_target, input, PC_W, redirect address.
REQ-012 SHALL have port pc_hazard, input, 1, decode-stage request to re-fetch the word currently in IF/ID.
REQ-013 SHALL have port int_req, input, 1, interrupt request, single-cycle pulse.
REQ-014 SHALL have port if_id_instr, output, 16, registered instruction to decode; opcode in bits [15:11].
REQ-015 SHALL have port if_id_pc, output, PC_W, registered address of if_id_instr.
REQ-016 SHALL have port if_id_pc_next, output, PC_W, registered if_id_pc+1, used as the return address by CALL/INT.
REQ-017 SHALL have port nop_signal, output, 1, registered; high when IF/ID holds a bubble.
REQ-018 SHALL have port int_pending, output, 1, high while an accepted interrupt awaits injection.

Function
REQ-019 SHALL implement a state machine with states BOOT, RUN and INJECT.
REQ-020 In BOOT, imem_addr SHALL equal BOOT_ADDR; on the next edge pc <= imem_data zero-extended, IF/ID holds a bubble, and the state goes to RUN.
REQ-021 In RUN, next-pc priority SHALL be: branch_taken -> branch_target; else pc_hazard -> if_id_pc; else stall -> pc held; else pc+1 modulo 2^PC_W.
REQ-022 In RUN without stall, IF/ID SHALL load {imem_data, pc, pc+1} with nop_signal=0, unless flush, branch_taken or pc_hazard is high, in which case it loads a bubble.
REQ-023 A bubble SHALL be: if_id_instr=16'h0000 (NOP), nop_signal=1, and the pc fields held.
REQ-024 With stall high and flush/branch_taken/pc_hazard low, IF/ID SHALL hold all fields unchanged.
REQ-025 int_req SHALL set an internal pending flag (int_pending=1); further int_req pulses while pending SHALL be ignored.
REQ-026 On a RUN cycle with pending set, stall low and branch_taken/pc_hazard/flush low, the state SHALL go to INJECT and IF/ID SHALL load {INT_OPCODE,11'b0, pc, pc} with nop_signal=0; pc is not incremented; pending clears.
REQ-027 INJECT SHALL last one cycle, during which IF/ID loads a bubble and pc holds; the state then returns to RUN; control-flow redirect arrives via branch_taken.
REQ-028 branch_taken in INJECT SHALL be honoured per REQ-021 and SHALL still return the state to RUN.
REQ-029 Latency SHALL be one cycle from imem_data sampling to if_id_instr.

Reset
REQ-030 rst_n low SHALL asynchronously force state=BOOT, pc=BOOT_ADDR, pending=0, if_id_instr=0, if_id_pc=0, if_id_pc_next=0, nop_signal=1, int_pending=0.
REQ-031 rst_n asserted mid-operation SHALL discard any pending interrupt and in-flight instruction; the reset vector SHALL be re-read after release.

Structure
REQ-032 Opcode constants (OP_INT, OP_NOP), the NOP encoding and the state encoding SHALL live in the shared defines file.
REQ-033 The IF/ID register SHALL be a sub-module named if_id_reg with load, bubble and hold controls; PC logic and FSM stay in fetch_stage.

Verification
REQ-034 Boot: mem[0]=16'h0040, rst_n released -> imem_addr 0 in the first cycle, then 0x40; if_id_pc=0x40 one cycle later.
REQ-035 Sequential: mem[0x40..0x42]=A,B,C -> if_id_instr A,B,C on consecutive cycles; nop_signal=0.
REQ-036 Stall 2 cycles while holding B -> if_id_instr stays B and pc stays 0x42; C appears on the cycle after release.
REQ-037 branch_taken with target 0x100 while pc=0x44 -> next IF/ID is a bubble; the following IF/ID carries mem[0x100] with if_id_pc=0x100.
REQ-038 Pulse int_req at pc=0x50 -> IF/ID holds the INT opcode with if_id_pc_next=0x50, then a bubble; a second int_req during pending is ignored.
REQ-039 Drive pc_hazard with if_id_pc=0x60 -> a bubble, then 0x60 fetched again.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared opcodes, NOP encoding and fetch FSM states
package fetch_stage_pkg;

  localparam logic [4:0]  OP_NOP    = 5'b00000;
  localparam logic [4:0]  OP_INT    = 5'b11110;
  localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'b0};

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_INJECT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with bubble, hold and load controls
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  logic            hold,
  input  logic [15:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic [PC_W-1:0] pc_next_in,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next,
  output logic            nop
);

  // A bubble only replaces the instruction; the pc fields keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr   <= NOP_INSTR;
      pc      <= '0;
      pc_next <= '0;
      nop     <= 1'b1;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      nop   <= 1'b1;
    end else if (load && !hold) begin
      instr   <= instr_in;
      pc      <= pc_in;
      pc_next <= pc_next_in;
      nop     <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: boot vector, pc sequencing, interrupt injection
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] BOOT_ADDR  = '0,
  parameter logic [4:0]      INT_OPCODE = OP_INT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            pc_hazard,
  input  logic            int_req,
  output logic [15:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc,
  output logic [PC_W-1:0] if_id_pc_next,
  output logic            nop_signal,
  output logic            int_pending
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  fetch_state_e    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic            pending, pending_nxt;
  logic            redirect, inject;
  logic            ld, bub, hld;
  logic [15:0]     ld_instr;
  logic [PC_W-1:0] ld_pc, ld_pc_next;

  assign redirect    = branch_taken | pc_hazard | flush;
  assign inject      = (state == ST_RUN) & pending & ~stall & ~redirect;
  assign imem_addr   = (state == ST_BOOT) ? BOOT_ADDR : pc;
  assign int_pending = pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_BOOT;
      pc      <= BOOT_ADDR;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pending_nxt = pending | int_req;
    ld          = 1'b0;
    bub         = 1'b0;
    hld         = 1'b0;
    ld_instr    = imem_data;
    ld_pc       = pc;
    ld_pc_next  = pc + PC_ONE;
    case (state)
      ST_BOOT: begin
        pc_nxt    = PC_W'(imem_data);
        bub       = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken)      pc_nxt = branch_target;
        else if (pc_hazard)    pc_nxt = if_id_pc;
        else if (stall)        pc_nxt = pc;
        else if (inject)       pc_nxt = pc;
        else                   pc_nxt = pc + PC_ONE;

        if (redirect) begin
          bub = 1'b1;
        end else if (stall) begin
          hld = 1'b1;
        end else if (inject) begin
          // Return address is the un-incremented pc so the handler resumes here.
          ld          = 1'b1;
          ld_instr    = {INT_OPCODE, 11'b0};
          ld_pc_next  = pc;
          pending_nxt = 1'b0;
          state_nxt   = ST_INJECT;
        end else begin
          ld = 1'b1;
        end
      end
      ST_INJECT: begin
        if (branch_taken) pc_nxt = branch_target;
        bub       = 1'b1;
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  if_id_reg #(
    .PC_W(PC_W)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ld),
    .bubble    (bub),
    .hold      (hld),
    .instr_in  (ld_instr),
    .pc_in     (ld_pc),
    .pc_next_in(ld_pc_next),
    .instr     (if_id_instr),
    .pc        (if_id_pc),
    .pc_next   (if_id_pc_next),
    .nop       (nop_signal)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with behavioural model
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0, pc_hazard = 1'b0, int_req = 1'b0;
  logic [31:0] branch_target = '0;
  logic [15:0] if_id_instr;
  logic [31:0] if_id_pc, if_id_pc_next;
  logic        nop_signal, int_pending;

  logic [15:0] mem [0:1023];
  assign imem_data = mem[imem_addr[9:0]];

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc_hazard    (pc_hazard),
    .int_req      (int_req),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_pc_next(if_id_pc_next),
    .nop_signal   (nop_signal),
    .int_pending  (int_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: mode 0 = waiting for reset vector, 1 = fetching, 2 = one cycle after injection.
  int          m_mode;
  logic [31:0] m_pc, m_ipc, m_ipcn;
  logic [15:0] m_instr;
  logic        m_nop, m_pend;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_ipc = 32'h0; m_ipcn = 32'h0;
    m_instr = 16'h0; m_nop = 1'b1; m_pend = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", imem_addr, (m_mode == 0) ? 32'h0 : m_pc);
      check("if_id_instr", {16'h0, if_id_instr}, {16'h0, m_instr});
      check("if_id_pc", if_id_pc, m_ipc);
      check("if_id_pc_next", if_id_pc_next, m_ipcn);
      check("nop_signal", {31'h0, nop_signal}, {31'h0, m_nop});
      check("int_pending", {31'h0, int_pending}, {31'h0, m_pend});
    end
  end

  task automatic cyc(input logic br, input logic [31:0] tgt, input logic hz,
                     input logic st, input logic fl, input logic ir);
    logic [31:0] npc, nipc, nipcn;
    logic [15:0] ninstr;
    logic        nnop, npend;
    int          nmode;
    branch_taken = br; branch_target = tgt; pc_hazard = hz;
    stall = st; flush = fl; int_req = ir;
    npc = m_pc; nipc = m_ipc; nipcn = m_ipcn; ninstr = m_instr; nnop = m_nop;
    nmode = m_mode; npend = m_pend | ir;
    if (m_mode == 0) begin
      npc = {16'h0, mem[0]};
      ninstr = 16'h0; nnop = 1'b1; nmode = 1;
    end else if (m_mode == 2) begin
      if (br) npc = tgt;
      ninstr = 16'h0; nnop = 1'b1; nmode = 1;
    end else begin
      if (br)                     npc = tgt;
      else if (hz)                npc = m_ipc;
      else if (st)                npc = m_pc;
      else if (m_pend && !fl)     npc = m_pc;
      else                        npc = m_pc + 32'd1;
      if (br || hz || fl) begin
        ninstr = 16'h0; nnop = 1'b1;
      end else if (!st && m_pend) begin
        ninstr = {OP_INT, 11'b0}; nipc = m_pc; nipcn = m_pc; nnop = 1'b0;
        npend = 1'b0; nmode = 2;
      end else if (!st) begin
        ninstr = mem[m_pc[9:0]]; nipc = m_pc; nipcn = m_pc + 32'd1; nnop = 1'b0;
      end
    end
    @(posedge clk);
    m_pc = npc; m_ipc = nipc; m_ipcn = nipcn; m_instr = ninstr;
    m_nop = nnop; m_mode = nmode; m_pend = npend;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0040;
    mem[32'h40] = 16'h1234;
    mem[32'h41] = 16'h2345;
    mem[32'h42] = 16'h3456;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_instr", {16'h0, if_id_instr}, 32'h0);
    check("rst_nop", {31'h0, nop_signal}, 32'h1);
    check("rst_pc", if_id_pc, 32'h0);
    rst_n = 1'b1;
    check("boot_addr", imem_addr, 32'h0);

    cyc(0, 0, 0, 0, 0, 0);
    check("boot_vector", imem_addr, 32'h40);
    check("boot_bubble", {31'h0, nop_signal}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0);
    check("seq_a", {16'h0, if_id_instr}, 32'h1234);
    check("seq_a_pc", if_id_pc, 32'h40);
    check("seq_a_pcn", if_id_pc_next, 32'h41);
    check("seq_a_nop", {31'h0, nop_signal}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    check("seq_b", {16'h0, if_id_instr}, 32'h2345);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 1, 0, 0);
      check("stall_b", {16'h0, if_id_instr}, 32'h2345);
      check("stall_pc", imem_addr, 32'h42);
    end
    cyc(0, 0, 0, 0, 0, 0);
    check("seq_c", {16'h0, if_id_instr}, 32'h3456);
    check("seq_c_pc", if_id_pc, 32'h42);
    cyc(0, 0, 0, 0, 0, 0);
    check("pc_44", imem_addr, 32'h44);

    cyc(1, 32'h100, 0, 0, 0, 0);
    check("br_bubble", {31'h0, nop_signal}, 32'h1);
    check("br_bubble_instr", {16'h0, if_id_instr}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    check("br_tgt_pc", if_id_pc, 32'h100);
    check("br_tgt_instr", {16'h0, if_id_instr}, {16'h0, mem[32'h100]});

    cyc(1, 32'h50, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1);
    check("int_pend_set", {31'h0, int_pending}, 32'h1);
    cyc(0, 0, 0, 0, 0, 1);
    check("int_opcode", {27'h0, if_id_instr[15:11]}, {27'h0, OP_INT});
    check("int_ret", if_id_pc_next, 32'h50);
    check("int_pend_clr", {31'h0, int_pending}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    check("int_bubble", {31'h0, nop_signal}, 32'h1);
    check("int_hold_pc", imem_addr, 32'h50);
    check("int_second_ignored", {31'h0, int_pending}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    check("int_resume", if_id_pc, 32'h50);

    cyc(1, 32'h60, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("hz_pre_pc", if_id_pc, 32'h60);
    cyc(0, 0, 1, 0, 0, 0);
    check("hz_bubble", {31'h0, nop_signal}, 32'h1);
    check("hz_refetch_addr", imem_addr, 32'h60);
    cyc(0, 0, 0, 0, 0, 0);
    check("hz_refetch_pc", if_id_pc, 32'h60);
    check("hz_refetch_instr", {16'h0, if_id_instr}, {16'h0, mem[32'h60]});

    cyc(0, 0, 0, 0, 0, 1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_pend", {31'h0, int_pending}, 32'h0);
    check("async_rst_nop", {31'h0, nop_signal}, 32'h1);
    check("async_rst_instr", {16'h0, if_id_instr}, 32'h0);
    check("async_rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    check("reboot_vector", imem_addr, 32'h40);

    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 99) < 10, 32'($urandom_range(0, 1023)),
          $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 6);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
